// File: rtl/reg_file.sv
// 32-entry register file with two combinational read ports and registered operand latches A/B.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [4:0]        RA,
  input  logic [4:0]        RB,
  input  logic [4:0]        WA,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] rdA,
  output logic [DATA_W-1:0] rdB,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  // Register 0 is hard-wired to zero on the read side, so its storage is never consulted.
  always_comb begin
    w_rd_a = (RA == 5'd0) ? '0 : r_regs[RA];
    w_rd_b = (RB == 5'd0) ? '0 : r_regs[RB];
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && (WA != 5'd0) && (WA == RA)) w_rd_a = WD;
    if (RegWrite && (WA != 5'd0) && (WA == RB)) w_rd_b = WD;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the whole array is cleared on reset so no X can ever leave it; a reset
      // also outranks any write presented in the same cycle.
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (RegWrite && (WA != 5'd0)) begin
        r_regs[WA] <= WD;
      end
      r_a <= w_rd_a;
      r_b <= w_rd_b;
    end
  end

  assign rdA = w_rd_a;
  assign rdB = w_rd_b;
  assign A   = r_a;
  assign B   = r_b;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: expectations are queued when stimulus is driven and
// compared when the read ports settle (comb queue) or after the next edge (latch queue).
module tb_reg_file;

  typedef struct {
    string       tag;
    int          sel;  // 0 rdA, 1 rdB, 2 A, 3 B
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RegWrite = 1'b0;
  logic [4:0]  RA = '0;
  logic [4:0]  RB = '0;
  logic [4:0]  WA = '0;
  logic [31:0] WD = '0;
  logic [31:0] rdA;
  logic [31:0] rdB;
  logic [31:0] A;
  logic [31:0] B;

  logic [31:0] model [32];
  exp_t        sb_comb [$];
  exp_t        sb_latch [$];
  int          vectors = 0;
  int          errors  = 0;

  reg_file #(.DATA_W(32), .NREGS(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .RegWrite (RegWrite),
    .RA       (RA),
    .RB       (RB),
    .WA       (WA),
    .WD       (WD),
    .rdA      (rdA),
    .rdB      (rdB),
    .A        (A),
    .B        (B)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return rdA;
      1:       return rdB;
      2:       return A;
      default: return B;
    endcase
  endfunction

  // Expected combinational read of addr given the model and the inputs currently driven.
  function automatic logic [31:0] exp_rd(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && (WA != 5'd0) && (WA == addr)) return WD;
`endif
    return model[addr];
  endfunction

  task automatic drive(input logic rs, input logic rw, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
    @(negedge clk);
    rst = rs; RegWrite = rw; WA = wa; WD = wd; RA = ra; RB = rb;
    #1;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (RegWrite && (WA != 5'd0)) begin
      model[WA] = WD;
    end
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    clock_edge();
    clock_edge();
    sb_latch.push_back('{tag:"reset_A", sel:2, val:32'h0});
    sb_latch.push_back('{tag:"reset_B", sel:3, val:32'h0});
    while (sb_latch.size() > 0) begin
      e = sb_latch.pop_front(); vectors++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
    drive(1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    sb_comb.push_back('{tag:"reset_rdA_r5", sel:0, val:32'h0});
    sb_comb.push_back('{tag:"reset_rdB_r0", sel:1, val:32'h0});
    while (sb_comb.size() > 0) begin
      e = sb_comb.pop_front(); vectors++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
  endtask

  task automatic test_basic_write();
    exp_t e;
    drive(1'b0, 1'b1, 5'd8, 32'h12345678, 5'd0, 5'd0);
    clock_edge();
    drive(1'b0, 1'b0, 5'd8, 32'h0, 5'd8, 5'd8);
    sb_comb.push_back('{tag:"basic_rdA", sel:0, val:32'h12345678});
    sb_comb.push_back('{tag:"basic_rdB", sel:1, val:32'h12345678});
    sb_latch.push_back('{tag:"basic_A", sel:2, val:32'h12345678});
    sb_latch.push_back('{tag:"basic_B", sel:3, val:32'h12345678});
    while (sb_comb.size() > 0) begin
      e = sb_comb.pop_front(); vectors++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
    clock_edge();
    while (sb_latch.size() > 0) begin
      e = sb_latch.pop_front(); vectors++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
  endtask

  task automatic test_reg0();
    exp_t e;
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    sb_comb.push_back('{tag:"reg0_rdA_during_write", sel:0, val:32'h0});
    sb_comb.push_back('{tag:"reg0_rdB_during_write", sel:1, val:32'h0});
    sb_latch.push_back('{tag:"reg0_A", sel:2, val:32'h0});
    while (sb_comb.size() > 0) begin
      e = sb_comb.pop_front(); vectors++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
    clock_edge();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    sb_comb.push_back('{tag:"reg0_rdA_after", sel:0, val:32'h0});
    while (sb_comb.size() > 0) begin
      e = sb_comb.pop_front(); vectors++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
    while (sb_latch.size() > 0) begin
      e = sb_latch.pop_front(); vectors++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    logic [31:0] exp_a;
    drive(1'b0, 1'b1, 5'd3, 32'h11, 5'd0, 5'd0);
    clock_edge();
    drive(1'b0, 1'b1, 5'd3, 32'h22, 5'd3, 5'd3);
`ifdef REGFILE_BYPASS_EN
    exp_a = 32'h22;
`else
    exp_a = 32'h11;
`endif
    sb_comb.push_back('{tag:"same_rdA", sel:0, val:exp_a});
    sb_comb.push_back('{tag:"same_rdB", sel:1, val:exp_a});
    sb_latch.push_back('{tag:"same_A", sel:2, val:exp_a});
    while (sb_comb.size() > 0) begin
      e = sb_comb.pop_front(); vectors++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
    clock_edge();
    while (sb_latch.size() > 0) begin
      e = sb_latch.pop_front(); vectors++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
    drive(1'b0, 1'b0, 5'd3, 32'h0, 5'd3, 5'd0);
    sb_comb.push_back('{tag:"same_rdA_next", sel:0, val:32'h22});
    while (sb_comb.size() > 0) begin
      e = sb_comb.pop_front(); vectors++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
  endtask

  task automatic test_write_enable();
    exp_t e;
    drive(1'b0, 1'b0, 5'd9, 32'hABCD, 5'd0, 5'd0);
    clock_edge();
    drive(1'b0, 1'b0, 5'd8, 32'h5555, 5'd9, 5'd8);
    clock_edge();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd8);
    sb_comb.push_back('{tag:"we_rdA_r9", sel:0, val:32'h0});
    sb_comb.push_back('{tag:"we_rdB_r8", sel:1, val:32'h12345678});
    while (sb_comb.size() > 0) begin
      e = sb_comb.pop_front(); vectors++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
  endtask

  task automatic test_sweep();
    exp_t e;
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
      clock_edge();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      sb_comb.push_back('{tag:$sformatf("sweep_rdA_%0d", i), sel:0, val:32'(i) * 32'h01010101});
      sb_comb.push_back('{tag:$sformatf("sweep_rdB_%0d", 31 - i), sel:1, val:32'(31 - i) * 32'h01010101});
      sb_latch.push_back('{tag:$sformatf("sweep_A_%0d", i), sel:2, val:32'(i) * 32'h01010101});
      sb_latch.push_back('{tag:$sformatf("sweep_B_%0d", 31 - i), sel:3, val:32'(31 - i) * 32'h01010101});
      while (sb_comb.size() > 0) begin
        e = sb_comb.pop_front(); vectors++;
        if (observe(e.sel) !== e.val) begin
          errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
        end
      end
      clock_edge();
      while (sb_latch.size() > 0) begin
        e = sb_latch.pop_front(); vectors++;
        if (observe(e.sel) !== e.val) begin
          errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    drive(1'b0, 1'b1, 5'd20, 32'hA0A0_0001, 5'd0, 5'd0);
    clock_edge();
    drive(1'b0, 1'b1, 5'd21, 32'hB0B0_0002, 5'd20, 5'd21);
    sb_comb.push_back('{tag:"b2b_rdA_r20", sel:0, val:exp_rd(5'd20)});
    sb_comb.push_back('{tag:"b2b_rdB_r21", sel:1, val:exp_rd(5'd21)});
    sb_latch.push_back('{tag:"b2b_A", sel:2, val:exp_rd(5'd20)});
    sb_latch.push_back('{tag:"b2b_B", sel:3, val:exp_rd(5'd21)});
    while (sb_comb.size() > 0) begin
      e = sb_comb.pop_front(); vectors++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
    clock_edge();
    while (sb_latch.size() > 0) begin
      e = sb_latch.pop_front(); vectors++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd21, 5'd21);
    sb_comb.push_back('{tag:"b2b_rdA_r21_next", sel:0, val:32'hB0B0_0002});
    while (sb_comb.size() > 0) begin
      e = sb_comb.pop_front(); vectors++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    drive(1'b0, 1'b1, 5'd10, 32'hAA, 5'd0, 5'd0);
    clock_edge();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd10);
    sb_latch.push_back('{tag:"mid_A_before", sel:2, val:32'hAA});
    clock_edge();
    while (sb_latch.size() > 0) begin
      e = sb_latch.pop_front(); vectors++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
    drive(1'b1, 1'b1, 5'd11, 32'h55, 5'd10, 5'd10);
    sb_latch.push_back('{tag:"mid_A_cleared", sel:2, val:32'h0});
    sb_latch.push_back('{tag:"mid_B_cleared", sel:3, val:32'h0});
    clock_edge();
    while (sb_latch.size() > 0) begin
      e = sb_latch.pop_front(); vectors++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
    drive(1'b0, 1'b1, 5'd10, 32'h99, 5'd11, 5'd10);
    sb_comb.push_back('{tag:"mid_rdA_r11_lost", sel:0, val:32'h0});
    while (sb_comb.size() > 0) begin
      e = sb_comb.pop_front(); vectors++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
    clock_edge();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd8);
    sb_comb.push_back('{tag:"mid_first_write", sel:0, val:32'h99});
    sb_comb.push_back('{tag:"mid_r8_cleared", sel:1, val:32'h0});
    while (sb_comb.size() > 0) begin
      e = sb_comb.pop_front(); vectors++;
      if (observe(e.sel) !== e.val) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, observe(e.sel), e.val);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    test_reset();
    test_basic_write();
    test_reg0();
    test_same_cycle();
    test_write_enable();
    test_back_to_back();
    test_sweep();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
